alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one instance of the combinational `alu` between NUM_REQ requesters, e.g. the execute stage and the address-generation unit.
- Each requester presents fn, funct7, a and b with a valid/ready handshake.
- A round-robin scheduler grants one request per cycle. The ALU result is registered and returned to the granted requester with a tag.
- Sits between the decode/issue logic and the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width; passed to `alu`.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ), requester-index width; derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  [NUM_REQ]  requester i has an operation pending.
- req_ready  output  [NUM_REQ]  requester i's operation is accepted this cycle.
- req_fn  input  [NUM_REQ] x alu_fn_t  ALU function per requester.
- req_funct7  input  [NUM_REQ] x funct7_t  ADD_SRL or SUB_SRA selector.
- req_a  input  [NUM_REQ] x WIDTH  operand a.
- req_b  input  [NUM_REQ] x WIDTH  operand b.
- resp_valid  output  1  registered result available.
- resp_id  output  IDX_W  index of the requester owning the result.
- resp_data  output  WIDTH  registered ALU result.
- resp_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset values: resp_valid=0, resp_id=0, resp_data=0, req_ready all 0. Round-robin pointer resets to 0, so requester 0 has highest priority after reset.
- FSM has two states.
  - IDLE: no result held.
  - HOLD: result registered and awaiting resp_ready.
- Grant is allowed in a cycle when state==IDLE, or state==HOLD && resp_ready. The second case allows back-to-back issue at one op/cycle.
- When grant is allowed and any req_valid is set:
  - Choose the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - Assert req_ready for that index only, combinationally.
  - Mux its fn/funct7/a/b into `alu`.
  - On the clock edge: resp_data <= alu out, resp_id <= index, resp_valid <= 1, state <= HOLD, pointer <= (index+1) mod NUM_REQ.
- If state==HOLD && resp_ready and no request is valid: resp_valid <= 0, state <= IDLE. resp_data and resp_id keep their last values.
- If state==HOLD && !resp_ready:
  - All req_ready=0.
  - resp_data, resp_id and resp_valid are held stable.
  - The pointer does not move.
- Latency: request accept to resp_valid is exactly 1 cycle.
- At most one req_ready is high per cycle. req_ready never depends on resp_data.
- Requesters must hold their inputs stable while req_valid is high and req_ready is low. The arbiter does not latch unaccepted inputs.
- Arithmetic is exactly that of `alu`: modulo 2^WIDTH wrap on ADD/SUB, with SUB_SRA selecting subtract / arithmetic shift. The arbiter adds no width extension.
- A requester that drops req_valid before being granted is simply skipped. Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Reset asserted mid-operation: at that edge the held result is discarded, resp_valid goes to 0, state goes to IDLE and the pointer goes to 0. No response is ever produced for an op accepted in the reset cycle.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- With the macro defined:
  - Adds output stat_grants [NUM_REQ] x 16 bits: per-requester grant counters.
  - Each counter increments on that requester's req_ready && req_valid and saturates at 16'hFFFF.
  - Counters clear on rst.
  - Adds input stat_clr (1 bit), a synchronous clear of all counters. stat_clr takes precedence over a same-cycle increment.
- Without the macro: neither port exists, and there are no counter flops.

Decomposition:
- Package ALU_FNS additionally holds:
  - alu_arb_state_t (IDLE, HOLD);
  - constant ALU_ARB_MAX_REQ = 8;
  - localparam STAT_W = 16.
- Sub-module rr_arbiter (parameter N) is natural.
  - Inputs: req[N], pointer, enable.
  - Outputs: one-hot grant[N], grant index, any_grant.
  - Purely combinational.
- The FSM, pointer, result register and `alu` instance live in alu_arbiter.

Test Plan:
- Reset, then req0 ADD_SUB/ADD_SRL a=32'h0000_0005 b=32'h0000_0006 with resp_ready=1 -> req_ready[0]=1 in cycle 0. Next cycle resp_valid=1, resp_id=0, resp_data=32'h0000_000B.
- req0 and req1 both valid continuously (AND a=32'hFFFF_0000 b=32'h0F0F_0F0F), resp_ready=1 -> grants alternate 0,1,0,1. resp_data=32'h0F0F_0000 every cycle, one op/cycle.
- Backpressure: issue req1 SUB_SRA ADD_SUB a=5 b=32'hFFFF_FFFA, then hold resp_ready=0 for 3 cycles -> resp_data=32'h0000_000B held with resp_valid=1, req_ready=0 throughout. Release -> next grant in the same cycle as acceptance.
- Wrap case ADD_SUB a=32'hFFFF_FFFF b=1 -> resp_data=32'h0000_0000. SRL_SRA/SUB_SRA a=32'h8000_0000 b=4 -> resp_data=32'hF800_0000.
- Assert rst while state==HOLD -> next cycle resp_valid=0, and a subsequent simultaneous req0/req1 grants req0 first.
- With ALU_ARBITER_STATS_EN: 5 grants to req1 -> stat_grants[1]=5, stat_grants[0] unchanged. Pulse stat_clr -> all counters 0 next cycle.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU function encodings and arbiter types.
// Included by alu, rr_arbiter and alu_arbiter.
package ALU_FNS;

  typedef enum logic [2:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR     = 3'd4,
    SRL_SRA = 3'd5,
    OR      = 3'd6,
    AND     = 3'd7
  } alu_fn_t;

  typedef enum logic {
    ADD_SRL = 1'b0,
    SUB_SRA = 1'b1
  } funct7_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } alu_arb_state_t;

  localparam int ALU_ARB_MAX_REQ = 8;
  localparam int STAT_W = 16;

endpackage

// File: rtl/alu.sv
// Combinational RV32-style integer ALU.
// funct7 selects subtract and arithmetic right shift.
module alu
  import ALU_FNS::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_fn_t          fn,
  input  funct7_t          funct7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] sh;
  logic            sub;

  assign sh  = b[SH_W-1:0];
  assign sub = (funct7 == SUB_SRA);

  // Result select by function code.
  always_comb begin
    y = '0;
    unique case (fn)
      ADD_SUB: y = sub ? (a - b) : (a + b);
      SLL:     y = a << sh;
      SLT:     y = {{(WIDTH-1){1'b0}},
                    ($signed(a) < $signed(b))};
      SLTU:    y = {{(WIDTH-1){1'b0}}, (a < b)};
      XOR:     y = a ^ b;
      SRL_SRA: y = sub ? WIDTH'($signed(a) >>> sh)
                       : (a >> sh);
      OR:      y = a | b;
      AND:     y = a & b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first request at
// or after ptr, wrapping modulo N.
module rr_arbiter
  import ALU_FNS::*;
#(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         enable,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any_grant
);

  int          j;
  logic [W-1:0] jj;

  // Scan from the pointer, stop at the first hit.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(ptr) + k) % N;
      jj = W'(j);
      if (enable && !any_grant && req[jj]) begin
        any_grant = 1'b1;
        idx       = jj;
        grant[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters.
// ALU_ARBITER_STATS_EN adds per-requester grant counters.
module alu_arbiter
  import ALU_FNS::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  alu_fn_t [NUM_REQ-1:0]           req_fn,
  input  funct7_t [NUM_REQ-1:0]           req_funct7,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  output logic                            resp_valid,
  output logic [IDX_W-1:0]                resp_id,
  output logic [WIDTH-1:0]                resp_data,
`ifdef ALU_ARBITER_STATS_EN
  output logic [NUM_REQ-1:0][STAT_W-1:0]  stat_grants,
  input  logic                            stat_clr,
`endif
  input  logic                            resp_ready
);

  alu_arb_state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gidx;
  logic             gany;
  logic             gen;
  logic [WIDTH-1:0] alu_y;
  logic             vld_d;
  logic             load;

  assign gen = (state_q == IDLE) || resp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .enable    (gen),
    .grant     (req_ready),
    .idx       (gidx),
    .any_grant (gany)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .fn     (req_fn[gidx]),
    .funct7 (req_funct7[gidx]),
    .a      (req_a[gidx]),
    .b      (req_b[gidx]),
    .y      (alu_y)
  );

  // Next state, pointer and result-load decision.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    vld_d   = resp_valid;
    load    = 1'b0;
    if (gany) begin
      load    = 1'b1;
      state_d = HOLD;
      vld_d   = 1'b1;
      ptr_d   = IDX_W'((int'(gidx) + 1) % NUM_REQ);
    end else if (state_q == HOLD && resp_ready) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end
  end

  // State, pointer and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      resp_valid <= vld_d;
      if (load) begin
        resp_id   <= gidx;
        resp_data <= alu_y;
      end
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  // Saturating grant counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_grants <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i] &&
            stat_grants[i] != {STAT_W{1'b1}}) begin
          stat_grants[i] <= stat_grants[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule
